// File: rtl/aibcr3aux_osc_scan_rdr.sv
// Scan read/write sequencer for an oscillator delay-chain scan path.
// Latency: done pulses CHAIN_LEN+1 cycles after the start cycle (CHAIN_LEN+2 with a capture cycle).
// Backpressure: none; start is accepted only in IDLE, starts seen while busy are dropped, not queued.
//
// Ports:
//   cp       - rising-edge clock
//   cd       - asynchronous active-high reset
//   start    - one-cycle pass request (sampled in IDLE only)
//   cap_en   - sampled with start; 1 inserts one functional capture cycle before shifting
//   wr_data  - pattern shifted into the chain, bit k goes out in shift cycle k
//   so       - serial scan-out from the last chain flop
//   se_n     - active-low scan enable to the chain (registered)
//   si       - serial scan-in to the first chain flop (registered)
//   busy     - pass in progress (registered)
//   done     - one-cycle pulse in the cycle rd_data carries the new read value
//   rd_data  - chain contents read out, bit 0 = flop nearest so
module aibcr3aux_osc_scan_rdr #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 cp,
  input  logic                 cd,
  input  logic                 start,
  input  logic                 cap_en,
  input  logic [CHAIN_LEN-1:0] wr_data,
  input  logic                 so,
  output logic                 se_n,
  output logic                 si,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rd_data
);

  localparam int CW = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_INIT = CW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_nxt;
  logic [CW-1:0]          cnt_q, cnt_nxt;
  logic [CHAIN_LEN-1:0]   wr_q, wr_nxt;       // remaining write bits, next one at bit 0
  logic [CHAIN_LEN-2:0]   sh_q, sh_nxt;       // read bits collected so far
  logic [CHAIN_LEN-1:0]   sh_cat;             // collected bits plus the current so
  logic                   se_n_nxt, si_nxt, busy_nxt, done_nxt;
  logic [CHAIN_LEN-1:0]   rd_nxt;

  // so enters at the top and everything moves down one place per shift
  // cycle, so after CHAIN_LEN cycles the value seen in cycle k sits at bit k.
  // The final cycle's so is folded straight into rd_data, which is why the
  // staging register is one bit short.
  assign sh_cat = {so, sh_q};

  always_ff @(posedge cp or posedge cd) begin
    if (cd) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      sh_q    <= '0;
      se_n    <= 1'b1;
      si      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      wr_q    <= wr_nxt;
      sh_q    <= sh_nxt;
      se_n    <= se_n_nxt;
      si      <= si_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      rd_data <= rd_nxt;
    end
  end

  // Outputs are computed for the state being entered and registered, so
  // se_n/si/busy/done never see a combinational path from any input.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    wr_nxt    = wr_q;
    sh_nxt    = sh_q;
    rd_nxt    = rd_data;
    se_n_nxt  = 1'b1;
    si_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          if (cap_en) begin
            state_nxt = CAPTURE;
            wr_nxt    = wr_data;
          end else begin
            // Going straight to SHIFT: present bit 0 now, keep the rest.
            state_nxt = SHIFT;
            se_n_nxt  = 1'b0;
            si_nxt    = wr_data[0];
            wr_nxt    = wr_data >> 1;
            cnt_nxt   = CNT_INIT;
          end
        end
      end

      CAPTURE: begin
        state_nxt = SHIFT;
        busy_nxt  = 1'b1;
        se_n_nxt  = 1'b0;
        si_nxt    = wr_q[0];
        wr_nxt    = wr_q >> 1;
        cnt_nxt   = CNT_INIT;
      end

      SHIFT: begin
        busy_nxt = 1'b1;
        sh_nxt   = sh_cat[CHAIN_LEN-1:1];
        if (cnt_q == '0) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          rd_nxt    = sh_cat;
        end else begin
          se_n_nxt = 1'b0;
          si_nxt   = wr_q[0];
          wr_nxt   = wr_q >> 1;
          cnt_nxt  = cnt_q - 1'b1;
        end
      end

      DONE: begin
        // start is deliberately not looked at here.
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aibcr3aux_osc_scan_rdr.sv
module tb_aibcr3aux_osc_scan_rdr;

  logic cp = 1'b0;
  always #5 cp = ~cp;

  logic cd;

  // 16-flop instance
  logic        start_a, cap_a, so_a, se_n_a, si_a, busy_a, done_a;
  logic [15:0] wr_a, rd_a;
  logic [15:0] ch_a, d_a;
  logic        den_a;

  // 2-flop instance
  logic        start_b, cap_b, so_b, se_n_b, si_b, busy_b, done_b;
  logic [1:0]  wr_b, rd_b;
  logic [1:0]  ch_b, d_b;
  logic        den_b;

  int n_cmp = 0;
  int n_bad = 0;

  aibcr3aux_osc_scan_rdr #(.CHAIN_LEN(16)) u_dut_a (
    .cp(cp), .cd(cd), .start(start_a), .cap_en(cap_a), .wr_data(wr_a), .so(so_a),
    .se_n(se_n_a), .si(si_a), .busy(busy_a), .done(done_a), .rd_data(rd_a)
  );

  aibcr3aux_osc_scan_rdr #(.CHAIN_LEN(2)) u_dut_b (
    .cp(cp), .cd(cd), .start(start_b), .cap_en(cap_b), .wr_data(wr_b), .so(so_b),
    .se_n(se_n_b), .si(si_b), .busy(busy_b), .done(done_b), .rd_data(rd_b)
  );

  // Behavioral chains: ch[0] is the last flop (drives so), ch[N-1] takes si.
  // Functional load of d only when den is set, so the chain holds otherwise.
  always @(posedge cp) begin
    if (!se_n_a) ch_a <= {si_a, ch_a[15:1]};
    else if (den_a) ch_a <= d_a;
    if (!se_n_b) ch_b <= {si_b, ch_b[1]};
    else if (den_b) ch_b <= d_b;
  end
  assign so_a = ch_a[0];
  assign so_b = ch_b[0];

  // Runs one pass on the 16-flop instance from a negedge and reports what it saw.
  task automatic pass_a(input logic cap, input logic [15:0] w,
                        output int lat, output int ncap, output int nlow, output int ndone,
                        output logic [15:0] si_seen, output logic [15:0] rd);
    lat = 0; ncap = 0; nlow = 0; ndone = 0; si_seen = '0; rd = '0;
    start_a = 1'b1; cap_a = cap; wr_a = w;
    for (int c = 1; c <= 30; c++) begin
      @(negedge cp);
      if (c == 1) begin start_a = 1'b0; cap_a = 1'b0; wr_a = '0; end
      if (!se_n_a) begin
        if (nlow < 16) si_seen[nlow] = si_a;
        nlow++;
      end else if (busy_a && !done_a) begin
        ncap++;
      end
      if (done_a) begin
        ndone++;
        if (lat == 0) begin lat = c; rd = rd_a; end
      end
    end
  endtask

  task automatic pass_b(input logic [1:0] w,
                        output int lat, output int nlow, output int ndone,
                        output logic [1:0] si_seen, output logic [1:0] rd);
    lat = 0; nlow = 0; ndone = 0; si_seen = '0; rd = '0;
    start_b = 1'b1; cap_b = 1'b0; wr_b = w;
    for (int c = 1; c <= 10; c++) begin
      @(negedge cp);
      if (c == 1) begin start_b = 1'b0; wr_b = '0; end
      if (!se_n_b) begin
        if (nlow < 2) si_seen[nlow] = si_b;
        nlow++;
      end
      if (done_b) begin
        ndone++;
        if (lat == 0) begin lat = c; rd = rd_b; end
      end
    end
  endtask

  task automatic test_reset;
    cd = 1'b1;
    start_a = 0; cap_a = 0; wr_a = '0; d_a = '0; den_a = 1'b1;
    start_b = 0; cap_b = 0; wr_b = '0; d_b = '0; den_b = 1'b1;
    repeat (3) @(negedge cp);
    // chains are now preloaded with zero
    den_a = 1'b0; den_b = 1'b0;
    n_cmp++; if ({se_n_a, si_a, busy_a, done_a} !== 4'b1000) begin n_bad++;
      $display("FAIL rst_ctl_a: got %b expected 1000", {se_n_a, si_a, busy_a, done_a}); end
    n_cmp++; if (rd_a !== 16'h0000) begin n_bad++;
      $display("FAIL rst_rd_a: got %h expected 0000", rd_a); end
    n_cmp++; if ({se_n_b, si_b, busy_b, done_b, rd_b} !== 6'b100000) begin n_bad++;
      $display("FAIL rst_b: got %b expected 100000", {se_n_b, si_b, busy_b, done_b, rd_b}); end
    cd = 1'b0;
    repeat (2) @(negedge cp);
    n_cmp++; if ({se_n_a, si_a, busy_a, done_a} !== 4'b1000) begin n_bad++;
      $display("FAIL post_rst_ctl_a: got %b expected 1000", {se_n_a, si_a, busy_a, done_a}); end
    n_cmp++; if (rd_a !== 16'h0000) begin n_bad++;
      $display("FAIL post_rst_rd_a: got %h expected 0000", rd_a); end
  endtask

  task automatic test_round_trip;
    int lat, ncap, nlow, ndone;
    logic [15:0] sis, rd;
    pass_a(1'b0, 16'hA5C3, lat, ncap, nlow, ndone, sis, rd);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL rt1_latency: got %0d expected 17", lat); end
    n_cmp++; if (nlow !== 16) begin n_bad++; $display("FAIL rt1_shift_cycles: got %0d expected 16", nlow); end
    n_cmp++; if (ncap !== 0) begin n_bad++; $display("FAIL rt1_capture_cycles: got %0d expected 0", ncap); end
    n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL rt1_done_pulses: got %0d expected 1", ndone); end
    n_cmp++; if (sis !== 16'hA5C3) begin n_bad++; $display("FAIL rt1_si_seq: got %h expected a5c3", sis); end
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL rt1_rd: got %h expected 0000", rd); end
    n_cmp++; if (rd_a !== 16'h0000) begin n_bad++; $display("FAIL rt1_rd_hold: got %h expected 0000", rd_a); end
    pass_a(1'b0, 16'h0000, lat, ncap, nlow, ndone, sis, rd);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL rt2_latency: got %0d expected 17", lat); end
    n_cmp++; if (rd !== 16'hA5C3) begin n_bad++; $display("FAIL rt2_rd: got %h expected a5c3", rd); end
    n_cmp++; if (rd_a !== 16'hA5C3) begin n_bad++; $display("FAIL rt2_rd_hold: got %h expected a5c3", rd_a); end
  endtask

  task automatic test_capture;
    int lat, ncap, nlow, ndone;
    logic [15:0] sis, rd;
    d_a = 16'h1234; den_a = 1'b1;
    pass_a(1'b1, 16'h5A5A, lat, ncap, nlow, ndone, sis, rd);
    den_a = 1'b0;
    n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL cap_latency: got %0d expected 18", lat); end
    n_cmp++; if (ncap !== 1) begin n_bad++; $display("FAIL cap_capture_cycles: got %0d expected 1", ncap); end
    n_cmp++; if (nlow !== 16) begin n_bad++; $display("FAIL cap_shift_cycles: got %0d expected 16", nlow); end
    n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL cap_done_pulses: got %0d expected 1", ndone); end
    n_cmp++; if (sis !== 16'h5A5A) begin n_bad++; $display("FAIL cap_si_seq: got %h expected 5a5a", sis); end
    n_cmp++; if (rd !== 16'h1234) begin n_bad++; $display("FAIL cap_rd: got %h expected 1234", rd); end
  endtask

  task automatic test_ignore_start;
    int d1, d2, ndone;
    d1 = 0; d2 = 0; ndone = 0;
    start_a = 1'b1; cap_a = 1'b0; wr_a = 16'h0F0F;
    for (int c = 1; c <= 40; c++) begin
      @(negedge cp);
      if (c == 1) start_a = 1'b0;
      if (c == 5) start_a = 1'b1;   // lands in SHIFT
      if (c == 6) start_a = 1'b0;
      if (done_a) begin
        ndone++;
        if (d1 == 0) begin d1 = c; start_a = 1'b1; end   // lands in DONE
        else d2 = c;
      end else if (d1 != 0 && c == d1 + 1) begin
        // start held high into the cycle after DONE
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++;
          $display("FAIL ign_busy_after_done: got %b expected 0", busy_a); end
      end else if (d1 != 0 && c == d1 + 2) begin
        start_a = 1'b0;
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++;
          $display("FAIL ign_new_pass_busy: got %b expected 1", busy_a); end
      end
    end
    start_a = 1'b0;
    n_cmp++; if (d1 !== 17) begin n_bad++; $display("FAIL ign_first_done: got %0d expected 17", d1); end
    n_cmp++; if (d2 !== 35) begin n_bad++; $display("FAIL ign_second_done: got %0d expected 35", d2); end
    n_cmp++; if (ndone !== 2) begin n_bad++; $display("FAIL ign_done_pulses: got %0d expected 2", ndone); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    logic [15:0] rd_before;
    ndone = 0;
    rd_before = rd_a;
    n_cmp++; if (rd_before === 16'h0000) begin n_bad++;
      $display("FAIL mid_rd_nonzero_before: got %h expected nonzero", rd_before); end
    start_a = 1'b1; cap_a = 1'b0; wr_a = 16'hFFFF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge cp);
      if (c == 1) start_a = 1'b0;
    end
    // now in shift cycle 7
    n_cmp++; if (se_n_a !== 1'b0) begin n_bad++; $display("FAIL mid_in_shift: got %b expected 0", se_n_a); end
    cd = 1'b1;
    #1;
    n_cmp++; if ({se_n_a, si_a, busy_a, done_a} !== 4'b1000) begin n_bad++;
      $display("FAIL mid_rst_ctl: got %b expected 1000", {se_n_a, si_a, busy_a, done_a}); end
    n_cmp++; if (rd_a !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_rd: got %h expected 0000", rd_a); end
    @(negedge cp);
    cd = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge cp);
      if (done_a) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d expected 0", ndone); end
    n_cmp++; if (rd_a !== 16'h0000) begin n_bad++; $display("FAIL mid_rd_after: got %h expected 0000", rd_a); end
    start_a = 1'b1;
    @(negedge cp);
    start_a = 1'b0;
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL mid_first_start: got %b expected 1", busy_a); end
    repeat (20) @(negedge cp);
  endtask

  task automatic test_chain2;
    int lat, nlow, ndone;
    logic [1:0] sis, rd;
    pass_b(2'b10, lat, nlow, ndone, sis, rd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL c2_latency: got %0d expected 3", lat); end
    n_cmp++; if (nlow !== 2) begin n_bad++; $display("FAIL c2_shift_cycles: got %0d expected 2", nlow); end
    n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL c2_done_pulses: got %0d expected 1", ndone); end
    n_cmp++; if (sis !== 2'b10) begin n_bad++; $display("FAIL c2_si_seq: got %b expected 10", sis); end
    n_cmp++; if (rd !== 2'b00) begin n_bad++; $display("FAIL c2_rd1: got %b expected 00", rd); end
    pass_b(2'b00, lat, nlow, ndone, sis, rd);
    n_cmp++; if (rd !== 2'b10) begin n_bad++; $display("FAIL c2_rd2: got %b expected 10", rd); end
    n_cmp++; if (nlow !== 2) begin n_bad++; $display("FAIL c2_shift_cycles2: got %0d expected 2", nlow); end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_capture();
    test_ignore_start();
    test_reset_mid();
    test_chain2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
